// File: rtl/vend_pkg.sv
// Shared encodings for the vending front end: coin codes and the emitter state set,
// so coin_acceptor and vending_machine agree on what travels on the in[1:0] bus.
package vend_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_1    = 2'b01;
    localparam coin_t COIN_2    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_GAP  = 2'b10
    } emit_state_t;

    // Only one of the two events is expected when this is used; 2 Rs wins otherwise.
    function automatic coin_t coin_select(input logic ev1, input logic ev2);
        if (ev2)
            return COIN_2;
        else if (ev1)
            return COIN_1;
        else
            return COIN_NONE;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor side-band bundle: raw sensors and hold in, coin stream and status out.
interface coin_acceptor_if
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    logic                            coin1_sense;
    logic                            coin2_sense;
    logic                            hold;
    coin_t                           coin_code;
    logic                            reject;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

    modport master (
        input  coin1_sense, coin2_sense, hold,
        output coin_code, reject, fifo_count
    );

    modport slave (
        output coin1_sense, coin2_sense, hold,
        input  coin_code, reject, fifo_count
    );
endinterface

// File: rtl/coin_acceptor_debounce.sv
// One coin sensor lane: 2-flop synchroniser, level debouncer and a rising-edge event pulse.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    output logic coin_event
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sense;
            sync2 <= sync1;
        end
    end

    // The level flips only once the disagreement has persisted past a full count,
    // so the counter never needs to climb beyond DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= 1'b0;
            count      <= '0;
            coin_event <= 1'b0;
        end else begin
            coin_event <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == 8'(DEBOUNCE_CYCLES)) begin
                level      <= sync2;
                count      <= '0;
                coin_event <= sync2;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces both sensors, queues coins and meters them out to the
// vending machine as single-cycle codes separated by idle gaps.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input logic             clk,
    input logic             rst_n,
    coin_acceptor_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic        ev1;
    logic        ev2;
    coin_t       mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic        full;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        reject_next;
    logic        reject_q;

    emit_state_t state;
    emit_state_t state_next;
    logic [3:0]  gap_count;
    logic [3:0]  gap_next;
    coin_t       code_q;
    coin_t       code_next;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sense      (bus.coin1_sense),
        .coin_event (ev1)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sense      (bus.coin2_sense),
        .coin_event (ev2)
    );

    // A full queue still takes a coin when the emitter drains one on the same edge.
    always_comb begin
        push_req    = ev1 ^ ev2;
        full        = (count == CW'(FIFO_DEPTH));
        push        = push_req && (!full || pop);
        reject_next = (ev1 && ev2) || (push_req && !push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= COIN_NONE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_next;
            if (push) begin
                mem[wr_ptr] <= coin_select(ev1, ev2);
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gap_count <= '0;
            code_q    <= COIN_NONE;
        end else begin
            state     <= state_next;
            gap_count <= gap_next;
            code_q    <= code_next;
        end
    end

    // hold only matters in IDLE; a started emission always runs EMIT plus the full gap.
    always_comb begin
        state_next = state;
        gap_next   = gap_count;
        code_next  = COIN_NONE;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((count != '0) && !bus.hold) begin
                    pop        = 1'b1;
                    code_next  = mem[rd_ptr];
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_next = ST_GAP;
                gap_next   = 4'(GAP_CYCLES - 1);
            end
            ST_GAP: begin
                if (gap_count == '0)
                    state_next = ST_IDLE;
                else
                    gap_next = gap_count - 4'd1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.coin_code  = code_q;
    assign bus.reject     = reject_q;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: vector table, corner-case sequences and a
// random phase, all compared every cycle against a queue-based reference model.
module tb_coin_acceptor;
    import vend_pkg::*;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;
    int rej_seen   = 0;
    coin_t seen_codes[$];
    int    seen_edges[$];

    // Reference model: a sensor qualifies once D+1 consecutive synchronised samples
    // disagree with its current level; coins wait in a queue and a cooldown spaces them.
    bit    h1[$];
    bit    h2[$];
    bit    lvl1, lvl2, pend1, pend2;
    coin_t mq[$];
    int    cd;
    coin_t m_code   = COIN_NONE;
    logic  m_reject = 1'b0;

    task automatic modelReset();
        h1.delete();
        h2.delete();
        for (int i = 0; i < D + 3; i++) begin
            h1.push_back(1'b0);
            h2.push_back(1'b0);
        end
        lvl1 = 1'b0; lvl2 = 1'b0; pend1 = 1'b0; pend2 = 1'b0;
        mq.delete();
        cd = 0;
        m_code = COIN_NONE;
        m_reject = 1'b0;
    endtask

    task automatic modelStep();
        bit all1, all2, new1, new2, pop;
        int pre;
        h1.push_back(bus.coin1_sense);
        h2.push_back(bus.coin2_sense);
        while (h1.size() > D + 3) void'(h1.pop_front());
        while (h2.size() > D + 3) void'(h2.pop_front());
        all1 = 1'b1; all2 = 1'b1;
        for (int i = 0; i <= D; i++) begin
            if (h1[i] == lvl1) all1 = 1'b0;
            if (h2[i] == lvl2) all2 = 1'b0;
        end
        new1 = 1'b0; new2 = 1'b0;
        if (all1) begin lvl1 = !lvl1; new1 = lvl1; end
        if (all2) begin lvl2 = !lvl2; new2 = lvl2; end

        pre = mq.size();
        pop = (cd == 0) && (pre > 0) && !bus.hold;
        m_reject = 1'b0;
        if (pop) begin
            m_code = mq.pop_front();
            cd = GAP + 1;
        end else begin
            m_code = COIN_NONE;
            if (cd > 0) cd--;
        end
        if (pend1 && pend2)
            m_reject = 1'b1;
        else if (pend1 || pend2) begin
            if (pre < DEPTH || pop)
                mq.push_back(pend1 ? COIN_1 : COIN_2);
            else
                m_reject = 1'b1;
        end
        pend1 = new1;
        pend2 = new2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            modelReset();
        else
            modelStep();
    end

    task automatic applyStimulus(input bit c1, input bit c2, input bit h);
        bus.coin1_sense = c1;
        bus.coin2_sense = c2;
        bus.hold        = h;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.coin_code != COIN_NONE) begin
            seen_codes.push_back(bus.coin_code);
            seen_edges.push_back(cyc);
        end
        if (bus.reject) rej_seen++;
        checkOutput("model_code", int'(bus.coin_code), int'(m_code));
        checkOutput("model_reject", int'(bus.reject), int'(m_reject));
        checkOutput("model_count", int'(bus.fifo_count), mq.size());
    endtask

    task automatic clearSeen();
        seen_codes.delete();
        seen_edges.delete();
        rej_seen = 0;
    endtask

    task automatic insertCoin(input bit c1, input bit c2, input bit h);
        applyStimulus(c1, c2, h);
        repeat (8) tick();
        applyStimulus(1'b0, 1'b0, h);
        repeat (D + 8) tick();
    endtask

    typedef struct {
        string name;
        bit    c1;
        bit    c2;
        int    len;
        int    exp_code;
        int    exp_edge;
        int    exp_codes;
        int    exp_rejects;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first, first_code, base;
        int r1, r2, rh;
        bit s1, s2, sh;
        coin_t exp3[3];
        coin_t exp4[4];

        vecs[0] = '{"c1_10cyc",     1'b1, 1'b0, 10, 1, 8,  1, 0};
        vecs[1] = '{"c2_glitch3",   1'b0, 1'b1, 3,  0, -1, 0, 0};
        vecs[2] = '{"c2_6cyc",      1'b0, 1'b1, 6,  2, 8,  1, 0};
        vecs[3] = '{"c1_glitch1",   1'b1, 1'b0, 1,  0, -1, 0, 0};
        vecs[4] = '{"both_8cyc",    1'b1, 1'b1, 8,  0, -1, 0, 1};
        vecs[5] = '{"c2_20cyc",     1'b0, 1'b1, 20, 2, 8,  1, 0};

        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("reset_code", int'(bus.coin_code), 0);
        checkOutput("reset_reject", int'(bus.reject), 0);
        checkOutput("reset_count", int'(bus.fifo_count), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Vector table: single pulses, glitches and simultaneous coins.
        for (int v = 0; v < 6; v++) begin
            clearSeen();
            applyStimulus(vecs[v].c1, vecs[v].c2, 1'b0);
            base = cyc;
            for (int e = 0; e < 40; e++) begin
                tick();
                if (e + 1 == vecs[v].len) applyStimulus(1'b0, 1'b0, 1'b0);
            end
            first = -1;
            first_code = 0;
            if (seen_codes.size() > 0) begin
                first = seen_edges[0] - base - 1;
                first_code = int'(seen_codes[0]);
            end
            checkOutput({vecs[v].name, "_codes"}, seen_codes.size(), vecs[v].exp_codes);
            checkOutput({vecs[v].name, "_code"}, first_code, vecs[v].exp_code);
            checkOutput({vecs[v].name, "_edge"}, first, vecs[v].exp_edge);
            checkOutput({vecs[v].name, "_rejects"}, rej_seen, vecs[v].exp_rejects);
            checkOutput({vecs[v].name, "_count"}, int'(bus.fifo_count), 0);
        end

        // Three coins queued under hold, then drained in order.
        clearSeen();
        insertCoin(1'b1, 1'b0, 1'b1);
        insertCoin(1'b0, 1'b1, 1'b1);
        insertCoin(1'b1, 1'b0, 1'b1);
        checkOutput("hold3_count", int'(bus.fifo_count), 3);
        checkOutput("hold3_quiet", seen_codes.size(), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        base = cyc;
        repeat (20) tick();
        exp3 = '{COIN_1, COIN_2, COIN_1};
        checkOutput("hold3_ncodes", seen_codes.size(), 3);
        if (seen_codes.size() == 3) begin
            for (int i = 0; i < 3; i++)
                checkOutput("hold3_order", int'(seen_codes[i]), int'(exp3[i]));
            checkOutput("hold3_release_lat", seen_edges[0] - base, 1);
            checkOutput("hold3_spacing", seen_edges[1] - seen_edges[0], 2 + GAP);
        end

        // Five coins into a four-deep queue.
        clearSeen();
        insertCoin(1'b1, 1'b0, 1'b1);
        insertCoin(1'b0, 1'b1, 1'b1);
        insertCoin(1'b1, 1'b0, 1'b1);
        insertCoin(1'b0, 1'b1, 1'b1);
        insertCoin(1'b1, 1'b0, 1'b1);
        checkOutput("full_rejects", rej_seen, 1);
        checkOutput("full_count", int'(bus.fifo_count), DEPTH);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (30) tick();
        exp4 = '{COIN_1, COIN_2, COIN_1, COIN_2};
        checkOutput("full_ncodes", seen_codes.size(), 4);
        if (seen_codes.size() == 4)
            for (int i = 0; i < 4; i++)
                checkOutput("full_order", int'(seen_codes[i]), int'(exp4[i]));

        // hold raised during EMIT must not stretch the pulse.
        clearSeen();
        insertCoin(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("emit_code", int'(bus.coin_code), int'(COIN_1));
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("emit_one_cycle", int'(bus.coin_code), int'(COIN_NONE));
        repeat (5) tick();
        checkOutput("emit_total", seen_codes.size(), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset while two coins wait and the emitter sits in its gap.
        insertCoin(1'b1, 1'b0, 1'b1);
        insertCoin(1'b0, 1'b1, 1'b1);
        insertCoin(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("gap_emit", int'(bus.coin_code), int'(COIN_1));
        tick();
        checkOutput("gap_count", int'(bus.fifo_count), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_code", int'(bus.coin_code), 0);
        checkOutput("rst_reject", int'(bus.reject), 0);
        checkOutput("rst_count", int'(bus.fifo_count), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clearSeen();
        repeat (30) tick();
        checkOutput("rst_no_codes", seen_codes.size(), 0);

        // A sensor held high across reset release is qualified once more.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clearSeen();
        repeat (20) tick();
        checkOutput("held_ncodes", seen_codes.size(), 1);
        if (seen_codes.size() == 1)
            checkOutput("held_code", int'(seen_codes[0]), int'(COIN_1));
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (15) tick();

        // Random sensor runs and hold toggling, checked cycle by cycle against the model.
        r1 = 0; r2 = 0; rh = 0;
        s1 = 1'b0; s2 = 1'b0; sh = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (r1 == 0) begin s1 = ($urandom_range(0, 2) == 0); r1 = $urandom_range(1, 14); end
            if (r2 == 0) begin s2 = ($urandom_range(0, 2) == 0); r2 = $urandom_range(1, 14); end
            if (rh == 0) begin sh = ($urandom_range(0, 1) == 0); rh = $urandom_range(1, 40); end
            r1--; r2--; rh--;
            applyStimulus(s1, s2, sh);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        checkOutput("drain_count", int'(bus.fifo_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
